// File: rtl/writeback_unit_if.sv
// Writeback request/response bus between the memory/execute stages, the
// writeback unit and the register file. misalign_trap exists only with WB_MISALIGN_TRAP_EN.
interface writeback_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int LANE_W = $clog2(XLEN/8)
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        wb_sel;
  logic              reg_write_en;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   alu_value;
  logic [XLEN-1:0]   pc_4_value;
  logic              alu_neg;
  logic              alu_ovf;
  logic [2:0]        load_funct3;
  logic [LANE_W-1:0] addr_lo;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              flush;
  logic              stall;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
`ifdef WB_MISALIGN_TRAP_EN
  logic              misalign_trap;
`endif

  modport master (
    output in_valid, wb_sel, reg_write_en, rd, alu_value, pc_4_value,
    output alu_neg, alu_ovf, load_funct3, addr_lo, mem_rvalid, mem_rdata, flush,
`ifdef WB_MISALIGN_TRAP_EN
    input  misalign_trap,
`endif
    input  in_ready, stall, reg_we, reg_waddr, reg_wdata
  );

  modport slave (
    input  in_valid, wb_sel, reg_write_en, rd, alu_value, pc_4_value,
    input  alu_neg, alu_ovf, load_funct3, addr_lo, mem_rvalid, mem_rdata, flush,
`ifdef WB_MISALIGN_TRAP_EN
    output misalign_trap,
`endif
    output in_ready, stall, reg_we, reg_waddr, reg_wdata
  );
endinterface

// File: rtl/writeback_unit.sv
// Registered writeback stage: result select, load extraction, load wait/drain FSM.
// Optional macro WB_MISALIGN_TRAP_EN diverts misaligned loads to DRAIN and pulses misalign_trap.
module writeback_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int LANE_W = $clog2(XLEN/8)
) (
  input logic            clk,
  input logic            rst,
  writeback_unit_if.slave wb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;
  localparam logic [1:0] SEL_SLT = 2'd3;

  // Lane-based load extraction; unsupported widths fall back to a zero-filled word.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [2:0]        funct3,
    input logic [LANE_W-1:0] lane,
    input logic [XLEN-1:0]   rdata
  );
    logic [XLEN-1:0] byte_w;
    logic [XLEN-1:0] half_w;
    logic [XLEN-1:0] word_w;
    logic [XLEN-1:0] res;
    byte_w = rdata >> {lane, 3'b000};
    half_w = rdata >> {lane[LANE_W-1:1], 4'b0000};
    word_w = rdata >> {lane >> 2, 5'b00000};
    case (funct3)
      3'b000:  res = XLEN'($signed(byte_w[7:0]));
      3'b100:  res = XLEN'(byte_w[7:0]);
      3'b001:  res = XLEN'($signed(half_w[15:0]));
      3'b101:  res = XLEN'(half_w[15:0]);
      3'b010:  res = XLEN'($signed(word_w[31:0]));
      3'b110:  res = XLEN'(word_w[31:0]);
      3'b011:  res = (XLEN == 64) ? rdata : XLEN'(word_w[31:0]);
      default: res = XLEN'(word_w[31:0]);
    endcase
    return res;
  endfunction

`ifdef WB_MISALIGN_TRAP_EN
  // Natural-alignment check for the access width encoded in funct3.
  function automatic logic is_misaligned(
    input logic [2:0]        funct3,
    input logic [LANE_W-1:0] lane
  );
    logic res;
    case (funct3)
      3'b001, 3'b101: res = lane[0];
      3'b010, 3'b110: res = (lane[1:0] != 2'b00);
      3'b011:         res = (lane != {LANE_W{1'b0}});
      default:        res = 1'b0;
    endcase
    return res;
  endfunction
`endif

  state_e            state_r;
  state_e            state_s;
  logic              reg_we_r;
  logic              reg_we_s;
  logic [REG_AW-1:0] reg_waddr_r;
  logic [REG_AW-1:0] reg_waddr_s;
  logic [XLEN-1:0]   reg_wdata_r;
  logic [XLEN-1:0]   reg_wdata_s;
  logic [2:0]        cap_funct3_r;
  logic [LANE_W-1:0] cap_lane_r;
  logic [REG_AW-1:0] cap_rd_r;
  logic              cap_we_r;
  logic              capture_s;
  logic              write_ok_s;
  logic [XLEN-1:0]   direct_value_s;
`ifdef WB_MISALIGN_TRAP_EN
  logic              trap_r;
  logic              trap_s;
`endif

  assign write_ok_s = wb.reg_write_en && (wb.rd != {REG_AW{1'b0}});

  // Non-load result source select.
  always_comb begin
    direct_value_s = wb.alu_value;
    case (wb.wb_sel)
      SEL_ALU: direct_value_s = wb.alu_value;
      SEL_PC4: direct_value_s = wb.pc_4_value;
      SEL_SLT: direct_value_s = XLEN'(wb.alu_neg ^ wb.alu_ovf);
      default: direct_value_s = wb.alu_value;
    endcase
  end

  // Next-state and next-output logic for the load wait/drain FSM.
  always_comb begin
    state_s     = state_r;
    reg_we_s    = 1'b0;
    reg_waddr_s = reg_waddr_r;
    reg_wdata_s = reg_wdata_r;
    capture_s   = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
    trap_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (wb.in_valid && !wb.flush) begin
          if (wb.wb_sel == SEL_MEM) begin
            capture_s = 1'b1;
`ifdef WB_MISALIGN_TRAP_EN
            if (is_misaligned(wb.load_funct3, wb.addr_lo)) begin
              trap_s  = 1'b1;
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_WAIT;
            end
`else
            state_s   = ST_WAIT;
`endif
          end else if (write_ok_s) begin
            reg_we_s    = 1'b1;
            reg_waddr_s = wb.rd;
            reg_wdata_s = direct_value_s;
          end else begin
            reg_we_s = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Flush wins over same-cycle read data.
        if (wb.flush) begin
          state_s = wb.mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (wb.mem_rvalid) begin
          state_s = ST_IDLE;
          if (cap_we_r) begin
            reg_we_s    = 1'b1;
            reg_waddr_s = cap_rd_r;
            reg_wdata_s = load_extract(cap_funct3_r, cap_lane_r, wb.mem_rdata);
          end else begin
            reg_we_s = 1'b0;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (wb.mem_rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, output and load-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      reg_we_r     <= 1'b0;
      reg_waddr_r  <= {REG_AW{1'b0}};
      reg_wdata_r  <= {XLEN{1'b0}};
      cap_funct3_r <= 3'b000;
      cap_lane_r   <= {LANE_W{1'b0}};
      cap_rd_r     <= {REG_AW{1'b0}};
      cap_we_r     <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      trap_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      reg_we_r    <= reg_we_s;
      reg_waddr_r <= reg_waddr_s;
      reg_wdata_r <= reg_wdata_s;
`ifdef WB_MISALIGN_TRAP_EN
      trap_r      <= trap_s;
`endif
      if (capture_s) begin
        cap_funct3_r <= wb.load_funct3;
        cap_lane_r   <= wb.addr_lo;
        cap_rd_r     <= wb.rd;
        cap_we_r     <= write_ok_s;
      end else begin
        cap_we_r     <= cap_we_r;
      end
    end
  end

  assign wb.in_ready  = (state_r == ST_IDLE);
  assign wb.stall     = (state_r != ST_IDLE);
  assign wb.reg_we    = reg_we_r;
  assign wb.reg_waddr = reg_waddr_r;
  assign wb.reg_wdata = reg_wdata_r;
`ifdef WB_MISALIGN_TRAP_EN
  assign wb.misalign_trap = trap_r;
`endif

endmodule
